fuzzy_mmio_master: RTL and testbench

Bus initiator for the fuzzy coprocessor's 8-bit MMIO slave. Sits between a streaming sample source and the coprocessor system top. On request it writes the 24 membership-function parameters and an init command. Per (T, dT) sample it writes the inputs, issues start, polls STATUS until the result is valid, reads G_out, and presents the result on a valid/ready output.

---
 rtl/fuzzy_mmio_pkg.sv | 63 ++++++
 rtl/fuzzy_mmio_master_xfer.sv | 56 +++++
 rtl/fuzzy_mmio_master.sv | 212 +++++++++++++++++++++
 tb/tb_fuzzy_mmio_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_mmio_pkg.sv
// Shared definitions for the fuzzy coprocessor MMIO master: register map,
// CTRL/STATUS bit positions, FSM state encoding and small address helpers.
package fuzzy_mmio_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    // Slave register map
    localparam logic [ADDR_W-1:0] ADDR_CTRL          = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_STATUS        = 8'h01;
    localparam logic [ADDR_W-1:0] ADDR_T_IN          = 8'h02;
    localparam logic [ADDR_W-1:0] ADDR_DT_IN         = 8'h03;
    localparam logic [ADDR_W-1:0] ADDR_G_OUT         = 8'h04;
    localparam logic [ADDR_W-1:0] ADDR_T_PARAM_BASE  = 8'h10;
    localparam logic [ADDR_W-1:0] ADDR_DT_PARAM_BASE = 8'h20;

    // CTRL / STATUS bit positions
    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_INIT_BIT     = 1;
    localparam int CTRL_REG_MODE_BIT = 2;
    localparam int CTRL_DT_MODE_BIT  = 3;
    localparam int STATUS_VALID_BIT  = 0;

    // Membership-function parameter set: 12 bytes for T, 12 for dT
    localparam int NUM_PARAMS       = 24;
    localparam int PARAMS_PER_INPUT = 12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_WR,
        ST_CFG_INIT,
        ST_WR_T,
        ST_WR_DT,
        ST_WR_START,
        ST_POLL_RD,
        ST_POLL_CAP,
        ST_G_RD,
        ST_G_CAP,
        ST_ABORT,      // cycle in which the abort CTRL write is on the bus
        ST_OUT
    } state_t;

    // Bus address of parameter byte k (0..23)
    function automatic logic [ADDR_W-1:0] param_addr(input logic [4:0] k);
        if (k < 5'(PARAMS_PER_INPUT)) begin
            return ADDR_T_PARAM_BASE + {3'b000, k};
        end
        return ADDR_DT_PARAM_BASE + {3'b000, k - 5'(PARAMS_PER_INPUT)};
    endfunction

    // CTRL register value with the given command and mode bits
    function automatic logic [DATA_W-1:0] ctrl_word(input logic start_bit, input logic init_bit,
                                                   input logic reg_mode_bit, input logic dt_mode_bit);
        logic [DATA_W-1:0] w;
        w                    = '0;
        w[CTRL_START_BIT]    = start_bit;
        w[CTRL_INIT_BIT]     = init_bit;
        w[CTRL_REG_MODE_BIT] = reg_mode_bit;
        w[CTRL_DT_MODE_BIT]  = dt_mode_bit;
        return w;
    endfunction

endpackage

// File: rtl/fuzzy_mmio_master_xfer.sv
// Single-access bus engine: turns a one-cycle read/write request into one
// registered bus cycle, and flags the cycle in which read data is valid.
module mmio_xfer
    import fuzzy_mmio_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              req_wr,
    input  logic              req_rd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic              cs_reg;
    logic              rd_reg;
    logic              wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              rd_pending_reg;

    // Launch the requested access on the next cycle; address/data are zero when idle
    always_ff @(posedge clk) begin
        if (srst) begin
            cs_reg         <= 1'b0;
            rd_reg         <= 1'b0;
            wr_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rd_pending_reg <= 1'b0;
        end else begin
            cs_reg         <= req_wr | req_rd;
            wr_reg         <= req_wr;
            rd_reg         <= req_rd & ~req_wr;
            addr_reg       <= (req_wr | req_rd) ? req_addr : '0;
            wdata_reg      <= req_wr ? req_wdata : '0;
            rd_pending_reg <= rd_reg;
        end
    end

    assign cs       = cs_reg;
    assign rd       = rd_reg;
    assign wr       = wr_reg;
    assign addr     = addr_reg;
    assign wdata    = wdata_reg;
    assign rd_valid = rd_pending_reg;
    assign rd_data  = rdata;

endmodule

// File: rtl/fuzzy_mmio_master.sv
// Bus initiator for the fuzzy coprocessor: loads membership parameters on
// request, and per sample writes inputs, starts, polls STATUS, reads G_out.
// Each state's next-state logic requests the access that is on the bus
// during the following state, so strobes come straight from registers.
module fuzzy_mmio_master
    import fuzzy_mmio_pkg::*;
#(
    parameter int POLL_MAX = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_load,
    input  logic [NUM_PARAMS*8-1:0] cfg_params,
    output logic                   cfg_busy,
    input  logic                   reg_mode,
    input  logic                   dt_mode,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_T,
    input  logic [DATA_W-1:0]      s_dT,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_G,
    output logic                   m_timeout,
    output logic                   cs,
    output logic                   rd,
    output logic                   wr,
    output logic [ADDR_W-1:0]      addr,
    output logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W-1:0]      rdata
);

    localparam logic [8:0] POLL_LIMIT = 9'(POLL_MAX);

    state_t            state_reg, state_next;
    logic [4:0]        idx_reg, idx_next;
    logic [7:0]        poll_cnt_reg, poll_cnt_next;
    logic [DATA_W-1:0] dt_reg, dt_next;
    logic [DATA_W-1:0] m_g_reg, m_g_next;
    logic              m_timeout_reg, m_timeout_next;
    logic              s_ready_reg;

    logic              req_wr, req_rd;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        idx_inc;

    // Parameter bytes as an array, byte k = cfg_params[8k+7:8k]
    logic [DATA_W-1:0] param_bytes [NUM_PARAMS];
    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_param_bytes
        assign param_bytes[gi] = cfg_params[8*gi +: 8];
    end

    assign idx_inc = idx_reg + 5'd1;

    // Next-state logic plus the bus request for the access in the next state
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        poll_cnt_next  = poll_cnt_reg;
        dt_next        = dt_reg;
        m_g_next       = m_g_reg;
        m_timeout_next = m_timeout_reg;
        req_wr         = 1'b0;
        req_rd         = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        case (state_reg)
            ST_IDLE: begin
                // s_ready_reg is low only in the first cycle out of reset
                if (s_ready_reg) begin
                    if (cfg_load) begin
                        state_next = ST_CFG_WR;
                        idx_next   = 5'd0;
                        req_wr     = 1'b1;
                        req_addr   = param_addr(5'd0);
                        req_wdata  = param_bytes[0];
                    end else if (s_valid) begin
                        state_next = ST_WR_T;
                        dt_next    = s_dT;
                        req_wr     = 1'b1;
                        req_addr   = ADDR_T_IN;
                        req_wdata  = s_T;
                    end
                end
            end
            ST_CFG_WR: begin
                req_wr = 1'b1;
                if (idx_reg == 5'(NUM_PARAMS - 1)) begin
                    state_next = ST_CFG_INIT;
                    req_addr   = ADDR_CTRL;
                    req_wdata  = ctrl_word(1'b0, 1'b1, reg_mode, dt_mode);
                end else begin
                    idx_next  = idx_inc;
                    req_addr  = param_addr(idx_inc);
                    req_wdata = param_bytes[idx_inc];
                end
            end
            ST_CFG_INIT: begin
                state_next = ST_IDLE;
            end
            ST_WR_T: begin
                state_next = ST_WR_DT;
                req_wr     = 1'b1;
                req_addr   = ADDR_DT_IN;
                req_wdata  = dt_reg;
            end
            ST_WR_DT: begin
                state_next = ST_WR_START;
                req_wr     = 1'b1;
                req_addr   = ADDR_CTRL;
                req_wdata  = ctrl_word(1'b1, 1'b0, reg_mode, dt_mode);
            end
            ST_WR_START: begin
                state_next    = ST_POLL_RD;
                poll_cnt_next = 8'd0;
                req_rd        = 1'b1;
                req_addr      = ADDR_STATUS;
            end
            ST_POLL_RD: begin
                state_next = ST_POLL_CAP;
            end
            ST_POLL_CAP: begin
                if (rd_valid && rd_data[STATUS_VALID_BIT]) begin
                    state_next = ST_G_RD;
                    req_rd     = 1'b1;
                    req_addr   = ADDR_G_OUT;
                end else if (({1'b0, poll_cnt_reg} + 9'd1) == POLL_LIMIT) begin
                    // Give up: clear start in the slave and report a timeout
                    state_next     = ST_ABORT;
                    m_g_next       = '0;
                    m_timeout_next = 1'b1;
                    req_wr         = 1'b1;
                    req_addr       = ADDR_CTRL;
                    req_wdata      = ctrl_word(1'b0, 1'b0, reg_mode, dt_mode);
                end else begin
                    state_next    = ST_POLL_RD;
                    poll_cnt_next = poll_cnt_reg + 8'd1;
                    req_rd        = 1'b1;
                    req_addr      = ADDR_STATUS;
                end
            end
            ST_G_RD: begin
                state_next = ST_G_CAP;
            end
            ST_G_CAP: begin
                state_next     = ST_OUT;
                m_g_next       = rd_data;
                m_timeout_next = 1'b0;
            end
            ST_ABORT: begin
                state_next = ST_OUT;
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            poll_cnt_reg  <= '0;
            dt_reg        <= '0;
            m_g_reg       <= '0;
            m_timeout_reg <= 1'b0;
            s_ready_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            poll_cnt_reg  <= poll_cnt_next;
            dt_reg        <= dt_next;
            m_g_reg       <= m_g_next;
            m_timeout_reg <= m_timeout_next;
            s_ready_reg   <= (state_next == ST_IDLE);
        end
    end

    mmio_xfer u_xfer (
        .clk       (clk),
        .srst      (rst),
        .req_wr    (req_wr),
        .req_rd    (req_rd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .cs        (cs),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

    // A pending configuration request takes the cycle away from the sample stream
    assign s_ready   = s_ready_reg & ~cfg_load;
    assign cfg_busy  = (state_reg == ST_CFG_WR) || (state_reg == ST_CFG_INIT);
    assign m_valid   = (state_reg == ST_OUT);
    assign m_G       = m_g_reg;
    assign m_timeout = m_timeout_reg;

endmodule

// File: tb/tb_fuzzy_mmio_master.sv
// Directed bench for fuzzy_mmio_master with a behavioural MMIO slave that
// logs every bus access with its clock-edge stamp.
module tb_fuzzy_mmio_master;

    typedef struct {
        bit         is_wr;
        logic [7:0] a;
        logic [7:0] d;
        int         stamp;
    } xact_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_load;
    logic [191:0] cfg_params;
    logic         cfg_busy;
    logic         reg_mode, dt_mode;
    logic         s_valid, s_ready;
    logic [7:0]   s_T, s_dT;
    logic         m_valid, m_ready;
    logic [7:0]   m_G;
    logic         m_timeout;
    logic         cs, rd, wr;
    logic [7:0]   addr, wdata;
    logic [7:0]   rdata;

    int total = 0;
    int bad   = 0;

    // slave model state
    int         valid_after = 0;   // STATUS valid from this poll on; 0 = never
    logic [7:0] g_value = 8'h00;
    int         polls = 0;
    int         edge_cnt = 0;
    int         bad_strobes = 0;
    xact_t      log_q[$];

    always #5 clk = ~clk;

    fuzzy_mmio_master #(.POLL_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_params (cfg_params),
        .cfg_busy   (cfg_busy),
        .reg_mode   (reg_mode),
        .dt_mode    (dt_mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_T        (s_T),
        .s_dT       (s_dT),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_G        (m_G),
        .m_timeout  (m_timeout),
        .cs         (cs),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata)
    );

    // MMIO slave: logs accesses, answers reads on the following cycle
    always @(posedge clk) begin
        if (!rst && ((cs && !(rd ^ wr)) || (!cs && (rd || wr)))) bad_strobes++;
        if (cs && wr) begin
            log_q.push_back('{1'b1, addr, wdata, edge_cnt});
            $display("bus wr addr=%02h data=%02h edge=%0d", addr, wdata, edge_cnt);
            if (addr == 8'h00 && wdata[0]) polls = 0;
        end
        if (cs && rd) begin
            log_q.push_back('{1'b0, addr, 8'h00, edge_cnt});
            $display("bus rd addr=%02h edge=%0d", addr, edge_cnt);
            if (addr == 8'h01) begin
                polls++;
                rdata <= (valid_after != 0 && polls >= valid_after) ? 8'h81 : 8'hFE;
            end else if (addr == 8'h04) begin
                rdata <= g_value;
            end else begin
                rdata <= 8'h00;
            end
        end else begin
            rdata <= 8'hFF;
        end
        edge_cnt++;
    end

    // Present a sample and wait (bounded) for acceptance; a0 = edge of acceptance
    task automatic send_sample(input logic [7:0] t, input logic [7:0] dt, output int a0);
        a0 = -1;
        @(posedge clk); #1;
        s_T = t; s_dT = dt; s_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (s_ready) begin
                a0 = edge_cnt;
                @(posedge clk); #1;
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    // Wait (bounded) for m_valid; rel = cycle index relative to a0, -1 on expiry
    task automatic wait_mvalid(input int a0, output int rel);
        rel = -1;
        for (int c = 0; c < 200; c++) begin
            if (m_valid) begin
                rel = edge_cnt - a0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({s_ready, cfg_busy, m_valid, cs, rd, wr, addr, wdata, m_G, m_timeout} !== 31'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d got=%08h want=0", i,
                         {s_ready, cfg_busy, m_valid, cs, rd, wr, addr, wdata, m_G, m_timeout});
            end
        end
        rst = 1'b0;
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_release_s_ready got=%b want=0", s_ready); end
        @(posedge clk); #1;
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready_rise got=%b want=1", s_ready); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_config;
        int a0, base, busy_cnt, busy_first;
        xact_t x;
        logic [7:0] ea, ed;
        for (int k = 0; k < 24; k++) cfg_params[8*k +: 8] = 8'(k + 1);
        reg_mode = 1'b0; dt_mode = 1'b0;
        @(posedge clk); #1;
        base = log_q.size();
        cfg_load = 1'b1;
        a0 = edge_cnt;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        busy_cnt = 0; busy_first = -1;
        for (int c = 0; c < 40; c++) begin
            if (cfg_busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = edge_cnt - a0;
            end
            @(posedge clk); #1;
        end
        total++;
        if (busy_cnt != 25) begin bad++; $display("FAIL cfg_busy_len got=%0d want=25", busy_cnt); end
        total++;
        if (busy_first != 1) begin bad++; $display("FAIL cfg_busy_start got=%0d want=1", busy_first); end
        total++;
        if (log_q.size() - base != 25) begin bad++; $display("FAIL cfg_access_count got=%0d want=25", log_q.size() - base); end
        for (int k = 0; k < 25; k++) begin
            if (k < 12)      begin ea = 8'(8'h10 + k);      ed = 8'(k + 1); end
            else if (k < 24) begin ea = 8'(8'h20 + k - 12); ed = 8'(k + 1); end
            else             begin ea = 8'h00;              ed = 8'h02;     end
            total++;
            if (base + k >= log_q.size()) begin
                bad++; $display("FAIL cfg_bus[%0d] got=none want addr=%02h data=%02h", k, ea, ed);
            end else begin
                x = log_q[base + k];
                if (!x.is_wr || x.a !== ea || x.d !== ed || x.stamp != a0 + 1 + k) begin
                    bad++;
                    $display("FAIL cfg_bus[%0d] got wr=%0b addr=%02h data=%02h cyc=%0d want wr=1 addr=%02h data=%02h cyc=%0d",
                             k, x.is_wr, x.a, x.d, x.stamp - a0, ea, ed, k + 1);
                end
            end
        end
    endtask

    task automatic test_sample;
        int a0, rel, base;
        xact_t x;
        bit         ew[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] ea[7] = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h01, 8'h01, 8'h04};
        logic [7:0] ed[7] = '{8'hF6, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        int         es[7] = '{1, 2, 3, 4, 6, 8, 10};
        valid_after = 3; g_value = 8'h5A;
        reg_mode = 1'b1; dt_mode = 1'b0; m_ready = 1'b0;
        base = log_q.size();
        send_sample(8'hF6, 8'h05, a0);
        wait_mvalid(a0, rel);
        total++;
        if (rel != 12) begin bad++; $display("FAIL sample_latency got=%0d want=12", rel); end
        total++;
        if (m_G !== 8'h5A) begin bad++; $display("FAIL sample_m_G got=%02h want=5a", m_G); end
        total++;
        if (m_timeout !== 1'b0) begin bad++; $display("FAIL sample_m_timeout got=%b want=0", m_timeout); end
        total++;
        if (log_q.size() - base != 7) begin bad++; $display("FAIL sample_access_count got=%0d want=7", log_q.size() - base); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (base + i >= log_q.size()) begin
                bad++; $display("FAIL sample_bus[%0d] got=none want addr=%02h", i, ea[i]);
            end else begin
                x = log_q[base + i];
                if (x.is_wr != ew[i] || x.a !== ea[i] || (ew[i] && x.d !== ed[i]) || x.stamp != a0 + es[i]) begin
                    bad++;
                    $display("FAIL sample_bus[%0d] got wr=%0b addr=%02h data=%02h cyc=%0d want wr=%0b addr=%02h data=%02h cyc=%0d",
                             i, x.is_wr, x.a, x.d, x.stamp - a0, ew[i], ea[i], ed[i], es[i]);
                end
            end
        end
    endtask

    // Entered with the previous result held in OUT and m_ready low
    task automatic test_backpressure;
        int base;
        base = log_q.size();
        s_T = 8'h11; s_dT = 8'h22; s_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (m_valid !== 1'b1 || m_G !== 8'h5A || s_ready !== 1'b0 || cs !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_hold cycle=%0d got valid=%b G=%02h s_ready=%b cs=%b want 1 5a 0 0",
                         c, m_valid, m_G, s_ready, cs);
            end
        end
        total++;
        if (log_q.size() != base) begin bad++; $display("FAIL backpressure_bus got=%0d want=0 accesses", log_q.size() - base); end
        m_ready = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++; $display("FAIL backpressure_release got valid=%b s_ready=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_timeout;
        int a0, rel, base;
        xact_t x;
        bit         ew[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ea[8] = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        logic [7:0] ed[8] = '{8'h10, 8'h20, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        int         es[8] = '{1, 2, 3, 4, 6, 8, 10, 12};
        valid_after = 0; reg_mode = 1'b0; dt_mode = 1'b0; m_ready = 1'b1;
        base = log_q.size();
        send_sample(8'h10, 8'h20, a0);
        wait_mvalid(a0, rel);
        total++;
        if (rel != 13) begin bad++; $display("FAIL timeout_latency got=%0d want=13", rel); end
        total++;
        if (m_G !== 8'h00 || m_timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_result got G=%02h to=%b want G=00 to=1", m_G, m_timeout);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (base + i >= log_q.size()) begin
                bad++; $display("FAIL timeout_bus[%0d] got=none want addr=%02h", i, ea[i]);
            end else begin
                x = log_q[base + i];
                if (x.is_wr != ew[i] || x.a !== ea[i] || (ew[i] && x.d !== ed[i]) || x.stamp != a0 + es[i]) begin
                    bad++;
                    $display("FAIL timeout_bus[%0d] got wr=%0b addr=%02h data=%02h cyc=%0d want wr=%0b addr=%02h data=%02h cyc=%0d",
                             i, x.is_wr, x.a, x.d, x.stamp - a0, ew[i], ea[i], ed[i], es[i]);
                end
            end
        end
        @(posedge clk); #1;
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL timeout_release got=%b want=0", m_valid); end
    endtask

    task automatic test_collision;
        int a0, acc, rel, base;
        xact_t x;
        bit         ew[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] ea[5] = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h04};
        logic [7:0] ed[5] = '{8'h33, 8'hCC, 8'h09, 8'h00, 8'h00};
        int         es[5] = '{27, 28, 29, 30, 32};
        logic [7:0] xa, xd;
        for (int k = 0; k < 24; k++) cfg_params[8*k +: 8] = 8'(8'h80 + k);
        reg_mode = 1'b0; dt_mode = 1'b1; m_ready = 1'b1;
        valid_after = 1; g_value = 8'h77;
        @(posedge clk); #1;
        base = log_q.size();
        cfg_load = 1'b1; s_valid = 1'b1; s_T = 8'h33; s_dT = 8'hCC;
        a0 = edge_cnt;
        #1;
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL collision_s_ready got=%b want=0", s_ready); end
        @(posedge clk); #1;
        cfg_load = 1'b0;
        acc = -1;
        for (int c = 0; c < 60; c++) begin
            if (s_ready) begin
                acc = edge_cnt - a0;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        total++;
        if (acc != 26) begin bad++; $display("FAIL collision_accept got=%0d want=26", acc); end
        wait_mvalid(a0, rel);
        total++;
        if (rel != 34) begin bad++; $display("FAIL collision_latency got=%0d want=34", rel); end
        total++;
        if (m_G !== 8'h77 || m_timeout !== 1'b0) begin
            bad++; $display("FAIL collision_result got G=%02h to=%b want G=77 to=0", m_G, m_timeout);
        end
        for (int k = 0; k < 30; k++) begin
            if (k < 12)      begin xa = 8'(8'h10 + k);      xd = 8'(8'h80 + k); end
            else if (k < 24) begin xa = 8'(8'h20 + k - 12); xd = 8'(8'h80 + k); end
            else if (k == 24) begin xa = 8'h00;             xd = 8'h0A;         end
            else             begin xa = ea[k-25];           xd = ed[k-25];      end
            total++;
            if (base + k >= log_q.size()) begin
                bad++; $display("FAIL collision_bus[%0d] got=none want addr=%02h", k, xa);
            end else begin
                x = log_q[base + k];
                if ((k < 25 && (!x.is_wr || x.a !== xa || x.d !== xd || x.stamp != a0 + 1 + k)) ||
                    (k >= 25 && (x.is_wr != ew[k-25] || x.a !== xa || (ew[k-25] && x.d !== xd) ||
                                 x.stamp != a0 + es[k-25]))) begin
                    bad++;
                    $display("FAIL collision_bus[%0d] got wr=%0b addr=%02h data=%02h cyc=%0d want addr=%02h data=%02h",
                             k, x.is_wr, x.a, x.d, x.stamp - a0, xa, xd);
                end
            end
        end
    endtask

    task automatic test_reset_mid_poll;
        int a0, base;
        valid_after = 0; m_ready = 1'b1;
        send_sample(8'h01, 8'h02, a0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({s_ready, cfg_busy, m_valid, cs, rd, wr, addr, wdata, m_G, m_timeout} !== 31'd0) begin
                bad++;
                $display("FAIL midpoll_reset_outputs cycle=%0d got=%08h want=0", i,
                         {s_ready, cfg_busy, m_valid, cs, rd, wr, addr, wdata, m_G, m_timeout});
            end
        end
        rst = 1'b0;
        base = log_q.size();
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL midpoll_release_s_ready got=%b want=0", s_ready); end
        @(posedge clk); #1;
        total++;
        if (s_ready !== 1'b1 || log_q.size() != base) begin
            bad++; $display("FAIL midpoll_idle got s_ready=%b accesses=%0d want 1 0", s_ready, log_q.size() - base);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_params = '0;
        reg_mode = 1'b0; dt_mode = 1'b0;
        s_valid = 1'b0; s_T = 8'h00; s_dT = 8'h00; m_ready = 1'b1;
        rdata = 8'hFF;
        test_reset();
        test_config();
        test_sample();
        test_backpressure();
        test_timeout();
        test_collision();
        test_reset_mid_poll();
        total++;
        if (bad_strobes != 0) begin bad++; $display("FAIL strobe_legality got=%0d want=0 bad cycles", bad_strobes); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
